// File: rtl/serial_sub64_pkg.sv
// Shared ALU definitions for the bit-serial subtractor: word width,
// sequencer states and the condition-code bit ordering used by execute.
package serial_sub64_pkg;

  localparam int unsigned WORD_W = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Condition-code ordering {ZF,SF,OF}, shared with the execute stage.
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

endpackage

// File: rtl/serial_sub64_if.sv
// Start/busy/done handshake and result bus of the serial subtractor.
interface serial_sub64_if
  import serial_sub64_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             zf;
  logic             sf;
  logic             of;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, zf, sf, of, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, zf, sf, of, borrow
  );
endinterface

// File: rtl/serial_sub64_sub_bit_cell.sv
// 1-bit full adder; the serial datapath reuses it once per clock.
module sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_sub64.sv
// Bit-serial a - b (LSB first) with Y86 condition codes and borrow;
// one result bit per clock behind a start/busy/done handshake.
module serial_sub64
  import serial_sub64_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned CNT_W = 7
) (
  input  logic           clk,
  input  logic           rst,
  serial_sub64_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-2:0] res;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             amsb;
  logic             bmsb;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  cc_t              cc_q;
  logic             borrow_q;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] final_diff;

  sub_bit_cell u_cell (
    .a    (areg[0]),
    .b    (breg[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  // The visible result is only replaced when the last bit lands, so the
  // collecting register is kept apart from diff.
  assign final_diff = {s_bit, res};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      areg     <= '0;
      breg     <= '0;
      res      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      amsb     <= 1'b0;
      bmsb     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      cc_q     <= '0;
      borrow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            areg   <= bus.a;
            breg   <= ~bus.b;
            carry  <= 1'b1;
            cnt    <= '0;
            amsb   <= bus.a[WIDTH-1];
            bmsb   <= bus.b[WIDTH-1];
            busy_q <= 1'b1;
            state  <= S_BUSY;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          areg  <= areg >> 1;
          breg  <= breg >> 1;
          carry <= c_bit;
          res   <= {s_bit, res[WIDTH-2:1]};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state    <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= final_diff;
            cc_q.zf  <= (final_diff == '0);
            cc_q.sf  <= s_bit;
            cc_q.of  <= (amsb != bmsb) && (s_bit != amsb);
            borrow_q <= ~c_bit;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.zf     = cc_q.zf;
  assign bus.sf     = cc_q.sf;
  assign bus.of     = cc_q.of;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub64.sv
// Self-checking bench for serial_sub64: directed cases plus random
// operations compared against an arithmetic a-b reference model.
module tb_serial_sub64;

  typedef struct packed {
    logic [63:0] d;
    logic        z;
    logic        s;
    logic        o;
    logic        br;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;
  logic prev_done = 1'b0;
  res_t pend = '0;
  res_t hold = '0;

  always #5 clk = ~clk;

  serial_sub64_if #(.WIDTH(64)) bus ();

  serial_sub64 #(.WIDTH(64), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b);
    res_t r;
    logic signed [64:0] w;
    w    = $signed({a[63], a}) - $signed({b[63], b});
    r.d  = a - b;
    r.z  = (r.d == 64'd0);
    r.s  = r.d[63];
    r.o  = (w[64] != w[63]);
    r.br = (a < b);
    return r;
  endfunction

  function automatic res_t dut_res();
    return {bus.diff, bus.zf, bus.sf, bus.of, bus.borrow};
  endfunction

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("busy_done_excl", {67'd0, bus.busy & bus.done}, 68'd0);
      if (bus.done) begin
        chk("done_pulse", {67'd0, prev_done}, 68'd0);
        chk("result", dut_res(), pend);
        hold = pend;
      end else begin
        chk("held", dut_res(), hold);
      end
      prev_done = bus.done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Caller is at a negedge; leaves the bench at the negedge of the done cycle.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                       input int poke_at, input logic [63:0] pa, input logic [63:0] pb);
    int cyc;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    pend      = model(a, b);
    @(negedge clk);
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      chk("busy_high", {67'd0, bus.busy}, 68'd1);
      if (cyc == poke_at) begin
        bus.start = 1'b1;
        bus.a     = pa;
        bus.b     = pb;
      end else begin
        bus.start = 1'b0;
        bus.a     = {$urandom, $urandom};
        bus.b     = {$urandom, $urandom};
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("latency", 68'(cyc), 68'd65);
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_mid_busy(input logic [63:0] a, input logic [63:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    chk("busy_before_rst", {67'd0, bus.busy}, 68'd1);
    rst  = 1'b1;
    hold = '0;
    @(negedge clk);
    chk("rst_mid_outputs", {bus.busy, bus.done, dut_res()}, 70'd0);
    rst = 1'b0;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 4))
      0:       return 64'h8000_0000_0000_0000;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'($urandom_range(0, 20));
      3:       return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] ra, rb;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.done, dut_res()}, 70'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Hand-computed values pinning the reference model itself.
    chk("model_t1", model(64'd2, -64'd13), {64'd15, 1'b0, 1'b0, 1'b0, 1'b1});
    chk("model_t2", model(-64'd2, 64'd13), {64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b1, 1'b0, 1'b0});
    chk("model_t4", model(64'h8000_0000_0000_0000, 64'd1),
        {64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0});
    chk("model_t5", {4'd0, model(64'd1134, 64'd8238).d}, {4'd0, -64'd7104});
    chk("model_t6", {4'd0, model(64'd7890678653, 64'd4238598110567).d}, {4'd0, -64'd4230707431914});

    do_op(64'd2, -64'd13, -1, '0, '0);
    chk("t1_literal", dut_res(), {64'd15, 1'b0, 1'b0, 1'b0, 1'b1});
    idle(2);
    do_op(-64'd2, 64'd13, -1, '0, '0);
    chk("t2_literal", dut_res(), {64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b1, 1'b0, 1'b0});
    idle(1);
    do_op(64'd0, 64'd0, -1, '0, '0);
    chk("t3_zero", dut_res(), {64'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    do_op(-64'd1, -64'd1, -1, '0, '0);
    idle(1);
    do_op(64'h8000_0000_0000_0000, 64'd1, -1, '0, '0);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, -64'd1, -1, '0, '0);
    chk("t4_of", {4'd0, bus.diff, bus.of}, {4'd0, 64'h8000_0000_0000_0000, 1'b1});
    idle(3);
    do_op(64'd1134, 64'd8238, 10, 64'd5, 64'd5);
    chk("t5_ignored_start", {4'd0, bus.diff}, {4'd0, -64'd7104});
    idle(3);
    chk("t5_idle_after", {66'd0, bus.busy, bus.done}, 68'd0);

    reset_mid_busy(64'd123456789, 64'd987654321);
    idle(1);
    do_op(64'd7890678653, 64'd4238598110567, -1, '0, '0);
    chk("t6_sf", {67'd0, bus.sf}, 68'd1);
    do_op(64'd1092835, 64'd1020, -1, '0, '0);
    chk("t6_b2b", {4'd0, bus.diff}, {4'd0, 64'd1091815});
    idle(2);

    for (int i = 0; i < 25; i++) begin
      ra = pick();
      rb = ($urandom_range(0, 5) == 0) ? ra : pick();
      do_op(ra, rb, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 64)) : -1,
            {$urandom, $urandom}, {$urandom, $urandom});
      idle($urandom_range(0, 2));
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
